// File: rtl/ex_mem_latch_if.sv
// Execute-to-memory pipeline bus: control inputs, captured fields and stage outputs.
interface ex_mem_latch_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_aluResult;
  logic [DATA_W-1:0] in_writeData;
  logic              in_memWrite;
  logic              in_memRead;
  logic              in_halt;
  logic              in_regWrite;
  logic [REG_W-1:0]  in_writeReg;
  logic              in_memToReg;

  logic              out_valid;
  logic [DATA_W-1:0] aluResult;
  logic [DATA_W-1:0] writeData;
  logic              memWrite;
  logic              memRead;
  logic              memReadorWrite;
  logic              halt;
  logic              regWrite;
  logic [REG_W-1:0]  writeReg;
  logic              memToReg;
  logic              halted;
  logic [CNT_W-1:0]  inst_count;

  // Execute side: drives the next instruction, observes the stage.
  modport master (
    output stall, flush, in_valid, in_aluResult, in_writeData, in_memWrite,
           in_memRead, in_halt, in_regWrite, in_writeReg, in_memToReg,
    input  out_valid, aluResult, writeData, memWrite, memRead, memReadorWrite,
           halt, regWrite, writeReg, memToReg, halted, inst_count
  );

  // Pipeline register side.
  modport slave (
    input  stall, flush, in_valid, in_aluResult, in_writeData, in_memWrite,
           in_memRead, in_halt, in_regWrite, in_writeReg, in_memToReg,
    output out_valid, aluResult, writeData, memWrite, memRead, memReadorWrite,
           halt, regWrite, writeReg, memToReg, halted, inst_count
  );
endinterface

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with stall, flush, halt-to-dump conversion and a
// wrapping count of valid instructions handed to the memory stage.
module ex_mem_latch #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst,   // asynchronous, active low
  ex_mem_latch_if.slave bus
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DUMP   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]        state_q,        state_d;
  logic              valid_q,        valid_d;
  logic [DATA_W-1:0] alu_result_q,   alu_result_d;
  logic [DATA_W-1:0] write_data_q,   write_data_d;
  logic              mem_write_q,    mem_write_d;
  logic              mem_read_q,     mem_read_d;
  logic              reg_write_q,    reg_write_d;
  logic [REG_W-1:0]  write_reg_q,    write_reg_d;
  logic              mem_to_reg_q,   mem_to_reg_d;
  logic [CNT_W-1:0]  inst_count_q,   inst_count_d;

  // Next-state logic: flush beats stall in RUN; DUMP lasts one cycle; HALTED is sticky.
  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a value unassigned (no latches).
    state_d      = state_q;
    valid_d      = valid_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    mem_write_d  = mem_write_q;
    mem_read_d   = mem_read_q;
    reg_write_d  = reg_write_q;
    write_reg_d  = write_reg_q;
    mem_to_reg_d = mem_to_reg_q;
    inst_count_d = inst_count_q;

    case (state_q)
      ST_RUN: begin
        if (bus.flush) begin
          valid_d      = 1'b0;
          alu_result_d = '0;
          write_data_d = '0;
          mem_write_d  = 1'b0;
          mem_read_d   = 1'b0;
          reg_write_d  = 1'b0;
          write_reg_d  = '0;
          mem_to_reg_d = 1'b0;
        end else if (!bus.stall) begin
          valid_d      = bus.in_valid;
          alu_result_d = bus.in_aluResult;
          write_data_d = bus.in_writeData;
          mem_write_d  = bus.in_memWrite;
          mem_read_d   = bus.in_memRead;
          reg_write_d  = bus.in_regWrite;
          write_reg_d  = bus.in_writeReg;
          mem_to_reg_d = bus.in_memToReg;
          if (bus.in_valid) begin
            inst_count_d = inst_count_q + CNT_W'(1);
            if (bus.in_halt) state_d = ST_DUMP;
          end
        end
      end
      ST_DUMP: begin
        // The halt entry stays visible for its dump cycle, then the stage empties.
        state_d = ST_HALTED;
        valid_d = 1'b0;
      end
      ST_HALTED: ;
      default: state_d = ST_RUN;
    endcase
  end

  // State and field registers, cleared the moment reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      valid_q      <= 1'b0;
      alu_result_q <= '0;
      write_data_q <= '0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      mem_to_reg_q <= 1'b0;
      inst_count_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q      <= state_d;
      valid_q      <= valid_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      mem_to_reg_q <= mem_to_reg_d;
      inst_count_q <= inst_count_d;
    end
  end

  logic run_ok;

  // Output gating: side effects only for a valid entry while running.
  always_comb begin
    run_ok             = valid_q & (state_q == ST_RUN);
    bus.out_valid      = valid_q;
    bus.aluResult      = alu_result_q;
    bus.writeData      = write_data_q;
    bus.memWrite       = mem_write_q & run_ok;
    bus.memRead        = mem_read_q & run_ok;
    bus.memReadorWrite = (mem_write_q | mem_read_q) & run_ok;
    bus.regWrite       = reg_write_q & run_ok;
    bus.writeReg       = write_reg_q;
    bus.memToReg       = mem_to_reg_q & (state_q != ST_HALTED);
    bus.halt           = (state_q == ST_DUMP);
    bus.halted         = (state_q == ST_HALTED);
    bus.inst_count     = inst_count_q;
  end

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed bench for ex_mem_latch: capture, stall, flush, halt/dump, async reset, wrap.
module tb_ex_mem_latch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ex_mem_latch_if #(.DATA_W(16), .REG_W(3), .CNT_W(16)) bus ();

  ex_mem_latch #(.DATA_W(16), .REG_W(3), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.stall        = 1'b0;
    bus.flush        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_aluResult = '0;
    bus.in_writeData = '0;
    bus.in_memWrite  = 1'b0;
    bus.in_memRead   = 1'b0;
    bus.in_halt      = 1'b0;
    bus.in_regWrite  = 1'b0;
    bus.in_writeReg  = '0;
    bus.in_memToReg  = 1'b0;
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_count", {16'd0, bus.inst_count}, 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    idle_inputs();
    do_reset();
    check("rst_alu", {16'd0, bus.aluResult}, 32'd0);
    check("rst_halted", {31'd0, bus.halted}, 32'd0);
    check("rst_halt", {31'd0, bus.halt}, 32'd0);

    // 1: store capture
    bus.in_valid = 1'b1; bus.in_memWrite = 1'b1;
    bus.in_aluResult = 16'h0040; bus.in_writeData = 16'hBEEF;
    step();
    check("t1_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t1_memwr", {31'd0, bus.memWrite}, 32'd1);
    check("t1_mrw", {31'd0, bus.memReadorWrite}, 32'd1);
    check("t1_alu", {16'd0, bus.aluResult}, 32'h0040);
    check("t1_wd", {16'd0, bus.writeData}, 32'hBEEF);
    check("t1_cnt", {16'd0, bus.inst_count}, 32'd1);

    // 2: load, then stall for 3 cycles with changing inputs
    bus.in_memWrite = 1'b0; bus.in_memRead = 1'b1; bus.in_aluResult = 16'h0100;
    bus.in_writeData = 16'h0000; bus.in_regWrite = 1'b1; bus.in_writeReg = 3'd5;
    bus.in_memToReg = 1'b1;
    step();
    check("t2_memrd", {31'd0, bus.memRead}, 32'd1);
    check("t2_wreg", {29'd0, bus.writeReg}, 32'd5);
    check("t2_cnt", {16'd0, bus.inst_count}, 32'd2);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_aluResult = 16'h0222 + 16'(i); bus.in_memRead = 1'b0; bus.in_memWrite = 1'b1;
      step();
      check("t2_stall_memrd", {31'd0, bus.memRead}, 32'd1);
      check("t2_stall_alu", {16'd0, bus.aluResult}, 32'h0100);
      check("t2_stall_cnt", {16'd0, bus.inst_count}, 32'd2);
    end
    bus.stall = 1'b0;
    step();
    check("t2_rel_alu", {16'd0, bus.aluResult}, 32'h0224);
    check("t2_rel_memwr", {31'd0, bus.memWrite}, 32'd1);
    check("t2_rel_memrd", {31'd0, bus.memRead}, 32'd0);
    check("t2_rel_cnt", {16'd0, bus.inst_count}, 32'd3);

    // 3: flush wins over stall
    bus.stall = 1'b1; bus.flush = 1'b1; bus.in_aluResult = 16'h0333;
    step();
    check("t3_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t3_memwr", {31'd0, bus.memWrite}, 32'd0);
    check("t3_regwr", {31'd0, bus.regWrite}, 32'd0);
    check("t3_alu", {16'd0, bus.aluResult}, 32'd0);
    check("t3_cnt", {16'd0, bus.inst_count}, 32'd3);

    // 5: halt -> one-cycle dump -> halted
    idle_inputs();
    bus.in_valid = 1'b1; bus.in_halt = 1'b1; bus.in_memWrite = 1'b1;
    bus.in_aluResult = 16'h0DEA;
    step();
    check("t5_halt", {31'd0, bus.halt}, 32'd1);
    check("t5_memwr", {31'd0, bus.memWrite}, 32'd0);
    check("t5_memrd", {31'd0, bus.memRead}, 32'd0);
    check("t5_mrw", {31'd0, bus.memReadorWrite}, 32'd0);
    check("t5_alu", {16'd0, bus.aluResult}, 32'h0DEA);
    check("t5_cnt", {16'd0, bus.inst_count}, 32'd4);
    check("t5_halted0", {31'd0, bus.halted}, 32'd0);
    bus.in_halt = 1'b0; bus.stall = 1'b1; bus.flush = 1'b1;
    step();
    check("t5_halt_off", {31'd0, bus.halt}, 32'd0);
    check("t5_halted", {31'd0, bus.halted}, 32'd1);
    check("t5_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.stall = 1'b0; bus.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_frz_memwr", {31'd0, bus.memWrite}, 32'd0);
      check("t5_frz_cnt", {16'd0, bus.inst_count}, 32'd4);
      check("t5_frz_halted", {31'd0, bus.halted}, 32'd1);
    end

    // 6: asynchronous reset in the dump cycle
    do_reset();
    bus.in_valid = 1'b1; bus.in_halt = 1'b1;
    step();
    check("t6_halt", {31'd0, bus.halt}, 32'd1);
    check("t6_cnt", {16'd0, bus.inst_count}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_halt", {31'd0, bus.halt}, 32'd0);
    check("t6_async_halted", {31'd0, bus.halted}, 32'd0);
    check("t6_async_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t6_async_cnt", {16'd0, bus.inst_count}, 32'd0);
    step();
    rst = 1'b1;
    idle_inputs();
    bus.in_valid = 1'b1; bus.in_memWrite = 1'b1; bus.in_aluResult = 16'h0055;
    step();
    check("t6_resume_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t6_resume_memwr", {31'd0, bus.memWrite}, 32'd1);
    check("t6_resume_cnt", {16'd0, bus.inst_count}, 32'd1);

    // 4: counter wrap
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
    end
    #1;
    check("t4_cnt_max", {16'd0, bus.inst_count}, 32'h0000FFFF);
    step();
    check("t4_cnt_wrap", {16'd0, bus.inst_count}, 32'd0);
    check("t4_valid", {31'd0, bus.out_valid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_mem_latch.md
Name: ex_mem_latch

Overview:
- Pipeline register between the execute stage and the memory stage of the 16-bit WISC pipeline.
- Captures the ALU result, store data and control bits, and supports stall (hold) and flush (bubble insertion).
- Converts an incoming halt instruction into a single-cycle memory-dump pulse and then freezes the pipeline.
- Keeps a wrapping count of valid instructions passed to the memory stage.

Parameters:
DATA_W, 16, width of address/data path
REG_W, 3, width of destination register index
CNT_W, 16, width of the instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  hold current contents (hazard unit)
flush  in  1  replace next contents with a bubble (branch resolve)
in_valid  in  1  execute stage holds a real instruction
in_aluResult  in  DATA_W  ALU result / memory address
in_writeData  in  DATA_W  store data
in_memWrite  in  1  store
in_memRead  in  1  load
in_halt  in  1  halt instruction
in_regWrite  in  1  writes register file
in_writeReg  in  REG_W  destination register
in_memToReg  in  1  writeback selects memory data
out_valid  out  1  stage holds a real instruction
aluResult  out  DATA_W  registered address/result
writeData  out  DATA_W  registered store data
memWrite  out  1  valid-gated store enable
memRead  out  1  valid-gated load enable
memReadorWrite  out  1  memWrite OR memRead
halt  out  1  one-cycle dump pulse to memory
regWrite  out  1  valid-gated register write
writeReg  out  REG_W  registered destination
memToReg  out  1  registered writeback select
halted  out  1  pipeline frozen after halt
inst_count  out  CNT_W  valid instructions captured, wrapping

Behaviour:
- Reset (rst low, asynchronous):
  - all registered fields 0, out_valid 0, inst_count 0.
  - FSM returns to RUN.
  - all outputs 0 within the same cycle the reset asserts.
- FSM states: RUN, DUMP, HALTED.
- RUN, per rising edge, in priority order:
  - flush=1: load a bubble. Valid 0, all control 0, data fields 0. Flush overrides stall.
  - else stall=1: hold all fields, counter unchanged.
  - else: capture all in_* fields, out_valid <= in_valid. inst_count increments by 1 when in_valid=1.
- RUN → DUMP on an edge that captures in_valid=1 and in_halt=1. No transition if the halt is flushed, stalled out, or in_valid=0.
- DUMP, exactly one cycle:
  - halt=1; the halt entry is visible on the outputs (aluResult, etc.).
  - memWrite/memRead forced 0, so the halt never accesses memory.
  - Next edge → HALTED regardless of stall or flush.
- HALTED:
  - out_valid 0, all control outputs 0, halt 0, halted 1.
  - inputs ignored; inst_count frozen.
  - only reset exits.
- Output gating:
  - memWrite = stored memWrite & out_valid & (state==RUN); memRead likewise; regWrite likewise.
  - memReadorWrite = memWrite | memRead, after gating.
  - halt = (state==DUMP).
- Latency: one cycle from in_* to outputs, unless stalled.
- Counter: inst_count wraps from 2^CNT_W-1 to 0 with no flag. The halt instruction is counted.
- Stall and flush in DUMP or HALTED have no effect.
- Reset asserted mid-DUMP clears the halt pulse immediately.

Test Plan:
1. Reset, then in_valid=1, in_memWrite=1, in_aluResult=16'h0040, in_writeData=16'hBEEF → next cycle memWrite=1, memReadorWrite=1, aluResult=16'h0040, writeData=16'hBEEF, inst_count=1.
2. Load captured, then stall=1 for 3 cycles while inputs change → outputs keep the load (memRead=1, aluResult unchanged), inst_count unchanged. Releasing the stall captures the new inputs.
3. stall=1 and flush=1 together with a valid store at the input → next cycle out_valid=0, memWrite=0, regWrite=0, inst_count unchanged.
4. inst_count preloaded to 16'hFFFF by 65535 valid captures, one more valid capture → inst_count=0.
5. Valid halt captured → halt=1 for exactly one cycle with memWrite=memRead=0, then halted=1. Later valid stores produce no memWrite, and inst_count stays frozen.
6. rst driven low during the DUMP cycle, asynchronously to clk → halt, halted, out_valid and inst_count go 0 immediately. After release, normal capture resumes.
